// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: memory op codes, LSU FSM states, default bus timeout and op-valid helper
package mem_lsu_pkg;
  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;
  localparam int LSU_TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_DONE} lsu_state_t;
  function automatic logic op_valid(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
  endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: req/ack data bus; master drives req/we/addr/sel/wdata, slave returns ack/rdata
interface mem_lsu_if #(parameter int ADDR_W = 32);
  logic req, we, ack;
  logic [ADDR_W-1:0] addr;
  logic [3:0] sel;
  logic [31:0] wdata, rdata;
  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu_lane.sv
// mem_lsu_lane: combinational byte enables, store replication and load extract/extend (op, addr[1:0], store_data, rdata -> sel, wdata, load_data)
module mem_lsu_lane import mem_lsu_pkg::*; #(
  parameter bit BIG_ENDIAN = 1
) (
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  logic [3:0] sel_be;
  logic [1:0] bl;
  logic hl;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    sel_be = (op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB}) ? 4'b1000 >> addr
           : (op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH}) ? (addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    sel = BIG_ENDIAN ? sel_be : {sel_be[0], sel_be[1], sel_be[2], sel_be[3]};
    wdata = op == MEM_OP_SB ? {4{store_data[7:0]}} : op == MEM_OP_SH ? {2{store_data[15:0]}} : store_data;
    bl = BIG_ENDIAN ? ~addr : addr;
    hl = BIG_ENDIAN ? ~addr[1] : addr[1];
    b = rdata[{bl, 3'b000} +: 8];
    h = rdata[{hl, 4'b0000} +: 16];
    load_data = op == MEM_OP_LB ? {{24{b[7]}}, b} : op == MEM_OP_LBU ? {24'h0, b}
              : op == MEM_OP_LH ? {{16{h[15]}}, h} : op == MEM_OP_LHU ? {16'h0, h} : rdata;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage with req/ack load/store bus (clk, rst active-low, ex_mem inputs, stall_i -> mem_wb outputs, stallreq_o, align_err_o, bus_err_o, bus master)
module mem_lsu import mem_lsu_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = LSU_TIMEOUT_DEF,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic        stall_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic        align_err_o,
  output logic        bus_err_o,
  mem_lsu_if.master   bus
);
  localparam int CW = $clog2(TIMEOUT + 2);
  lsu_state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] sel_q, sel;
  logic we_q, err_q, valid, is_half, is_word, is_store, misalign, go, tmo;
  logic [31:0] wdata_q, rdata_q, st_data, ld_data;
  mem_lsu_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .op(mem_op_i), .addr(mem_addr_i[1:0]), .store_data(store_data_i), .rdata(rdata_q),
    .sel(sel), .wdata(st_data), .load_data(ld_data)
  );
  always_comb begin
    valid = op_valid(mem_op_i);
    is_half = mem_op_i inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH};
    is_word = mem_op_i inside {MEM_OP_LW, MEM_OP_SW};
    is_store = mem_op_i inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
    misalign = (is_half && mem_addr_i[0]) || (is_word && mem_addr_i[1:0] != 2'b00);
    go = valid && !misalign;
    tmo = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) state_q <= !rst ? LSU_IDLE : state_d;
  always_ff @(posedge clk)
    if (!rst) begin
      cnt_q <= '0;
      addr_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= state_q == LSU_REQ ? cnt_q + 1'b1 : '0;
      if (state_q == LSU_IDLE && go) begin
        addr_q <= {mem_addr_i[ADDR_W-1:2], 2'b00};
        sel_q <= sel;
        we_q <= is_store;
        wdata_q <= st_data;
        err_q <= 1'b0;
      end
      if (state_q == LSU_REQ && bus.ack) rdata_q <= bus.rdata;
      if (state_q == LSU_REQ && !bus.ack && tmo) err_q <= 1'b1;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: state_d = go ? LSU_REQ : LSU_IDLE;
      LSU_REQ:  state_d = (bus.ack || tmo) ? LSU_DONE : LSU_REQ;
      LSU_DONE: state_d = stall_i ? LSU_DONE : LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end
  always_comb begin
    wd_o = rst ? wd_i : '0;
    whilo_o = rst && whilo_i;
    hi_o = rst ? hi_i : '0;
    lo_o = rst ? lo_i : '0;
    wdata_o = !rst ? '0 : (state_q == LSU_DONE && !we_q) ? ld_data : wdata_i;
    wreg_o = rst && wreg_i && !misalign && !(state_q == LSU_DONE && err_q);
    stallreq_o = rst && ((state_q == LSU_IDLE && go) || state_q == LSU_REQ);
    align_err_o = rst && misalign;
    bus_err_o = rst && state_q == LSU_DONE && err_q;
    bus.req = rst && state_q == LSU_REQ;
    bus.we = rst && we_q;
    bus.addr = rst ? addr_q : '0;
    bus.sel = rst ? sel_q : '0;
    bus.wdata = rst ? wdata_q : '0;
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven, directed and randomized checks of mem_lsu against a byte-level reference model
module tb_mem_lsu;
  import mem_lsu_pkg::*;
  localparam int TO = 4;
  localparam bit BE = 1;
  logic clk = 0, rst, wreg_i, wreg_o, whilo_i, whilo_o, stall_i, stallreq_o, align_err_o, bus_err_o;
  logic [4:0] wd_i, wd_o;
  logic [3:0] mem_op_i;
  logic [31:0] wdata_i, wdata_o, hi_i, hi_o, lo_i, lo_o, mem_addr_i, store_data_i;
  int checks = 0, errors = 0, req_total = 0;
  typedef struct {
    int stall_n, req_n;
    logic [31:0] res, ba, bwd;
    logic wr, be, al, we;
    logic [3:0] sel;
  } obs_t;
  typedef struct {
    logic [3:0] op;
    logic [31:0] a, sd, rd;
    int w;
    logic [31:0] e_res;
    logic [3:0] e_sel;
    logic [31:0] e_bwd;
  } vec_t;
  vec_t tbl[12];
  mem_lsu_if #(.ADDR_W(32)) bus ();
  mem_lsu #(.ADDR_W(32), .TIMEOUT(TO), .BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .whilo_i(whilo_i),
    .hi_i(hi_i), .lo_i(lo_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .stall_i(stall_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o),
    .lo_o(lo_o), .stallreq_o(stallreq_o), .align_err_o(align_err_o), .bus_err_o(bus_err_o), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.req) req_total++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] pass_data(input logic [31:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // Memory seen as four bytes at addresses base..base+3; expected results follow from byte addressing.
  function automatic obs_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int w);
    obs_t m;
    logic [7:0] mem [4];
    logic [7:0] b;
    logic [15:0] h;
    int sz, k0;
    m = '{default: 0};
    for (int k = 0; k < 4; k++) mem[k] = BE ? rd[8*(3-k) +: 8] : rd[8*k +: 8];
    sz = (op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB}) ? 1 : (op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH}) ? 2
       : (op inside {MEM_OP_LW, MEM_OP_SW}) ? 4 : 0;
    k0 = int'(a[1:0]);
    m.al = sz > 1 && (k0 % sz) != 0;
    m.res = pass_data(a);
    m.wr = !m.al;
    if (sz == 0 || m.al) return m;
    m.be = w >= TO;
    m.req_n = m.be ? TO : w + 1;
    m.stall_n = m.req_n + 1;
    m.wr = !m.be;
    for (int k = k0; k < k0 + sz; k++) m.sel[BE ? 3 - k : k] = 1'b1;
    m.we = op >= MEM_OP_SB;
    m.ba = {a[31:2], 2'b00};
    m.bwd = sz == 1 ? {4{sd[7:0]}} : sz == 2 ? {2{sd[15:0]}} : sd;
    if (!m.we) begin
      b = mem[k0];
      h = 16'h0;
      if (sz == 2) h = BE ? {mem[k0], mem[k0+1]} : {mem[k0+1], mem[k0]};
      case (op)
        MEM_OP_LB:  m.res = {{24{b[7]}}, b};
        MEM_OP_LBU: m.res = {24'h0, b};
        MEM_OP_LH:  m.res = {{16{h[15]}}, h};
        MEM_OP_LHU: m.res = {16'h0, h};
        default:    m.res = rd;
      endcase
    end
    return m;
  endfunction

  // Presents one op (caller is just past a posedge) and acks after w REQ cycles; returns in the first non-stalled cycle.
  task automatic xact(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                      input logic [31:0] rd, input int w, output obs_t o);
    mem_op_i = op;
    mem_addr_i = a;
    store_data_i = sd;
    bus.rdata = rd;
    bus.ack = 1'b0;
    wdata_i = pass_data(a);
    wreg_i = 1'b1;
    o = '{default: 0};
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stallreq_o) break;
      o.stall_n++;
      if (bus.req) begin
        if (o.req_n == 0) begin
          o.sel = bus.sel;
          o.we = bus.we;
          o.ba = bus.addr;
          o.bwd = bus.wdata;
        end
        o.req_n++;
      end
      bus.ack = bus.req && o.req_n > w;
    end
    o.res = wdata_o;
    o.wr = wreg_o;
    o.be = bus_err_o;
    o.al = align_err_o;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    mem_op_i = MEM_OP_NONE;
    bus.ack = 1'b0;
    stall_i = 1'b0;
  endtask

  task automatic cmp(input string n, input obs_t g, input obs_t e);
    chk({n, " stall_cycles"}, g.stall_n, e.stall_n);
    chk({n, " align_err"}, g.al, e.al);
    chk({n, " wreg"}, g.wr, e.wr);
    chk({n, " bus_err"}, g.be, e.be);
    if (!e.be) chk({n, " wdata"}, g.res, e.res);
    if (e.stall_n > 0) begin
      chk({n, " req_cycles"}, g.req_n, e.req_n);
      chk({n, " sel"}, g.sel, e.sel);
      chk({n, " we"}, g.we, e.we);
      chk({n, " addr"}, g.ba, e.ba);
      if (e.we) chk({n, " bus_wdata"}, g.bwd, e.bwd);
    end
  endtask

  initial begin
    obs_t g, e;
    int rt;
    logic [3:0] op;
    logic [31:0] a, sd, rd;
    int w;
    tbl[0]  = '{MEM_OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1]  = '{MEM_OP_LB,  32'h103, 32'h0,        32'h000000F0, 0, 32'hFFFFFFF0, 4'h1, 32'h0};
    tbl[2]  = '{MEM_OP_LBU, 32'h103, 32'h0,        32'h000000F0, 1, 32'h000000F0, 4'h1, 32'h0};
    tbl[3]  = '{MEM_OP_LH,  32'h102, 32'h0,        32'h00008001, 0, 32'hFFFF8001, 4'h3, 32'h0};
    tbl[4]  = '{MEM_OP_LHU, 32'h100, 32'h0,        32'h80011234, 0, 32'h00008001, 4'hC, 32'h0};
    tbl[5]  = '{MEM_OP_SH,  32'h202, 32'h1234ABCD, 32'h0,        0, 32'hC0DE0202, 4'h3, 32'hABCDABCD};
    tbl[6]  = '{MEM_OP_SB,  32'h301, 32'h00000055, 32'h0,        0, 32'hC0DE0301, 4'h4, 32'h55555555};
    tbl[7]  = '{MEM_OP_SW,  32'h400, 32'hCAFEF00D, 32'h0,        2, 32'hC0DE0400, 4'hF, 32'hCAFEF00D};
    tbl[8]  = '{MEM_OP_LB,  32'h100, 32'h0,        32'h7F000000, 3, 32'h0000007F, 4'h8, 32'h0};
    tbl[9]  = '{MEM_OP_LW,  32'h101, 32'h0,        32'h0,        0, 32'hC0DE0101, 4'h0, 32'h0};
    tbl[10] = '{MEM_OP_LH,  32'h103, 32'h0,        32'h0,        0, 32'hC0DE0103, 4'h0, 32'h0};
    tbl[11] = '{4'd12,      32'h105, 32'h0,        32'h0,        0, 32'hC0DE0105, 4'h0, 32'h0};
    rst = 1'b0;
    wd_i = 5'd7;
    wreg_i = 1'b1;
    wdata_i = 32'h0;
    whilo_i = 1'b1;
    hi_i = 32'h1111_2222;
    lo_i = 32'h3333_4444;
    mem_op_i = MEM_OP_LW;
    mem_addr_i = 32'h0;
    store_data_i = 32'h0;
    stall_i = 1'b0;
    bus.ack = 1'b0;
    bus.rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wd_o", wd_o, 5'd0);
    chk("reset hi_o", hi_o, 32'h0);
    chk("reset stallreq", stallreq_o, 1'b0);
    chk("reset req", bus.req, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_op_i = MEM_OP_NONE;
    @(negedge clk);
    chk("pass hi_o", hi_o, hi_i);
    chk("pass lo_o", lo_o, lo_i);
    chk("pass whilo_o", whilo_o, 1'b1);
    chk("pass wd_o", wd_o, 5'd7);
    idle();
    for (int i = 0; i < 12; i++) begin
      rt = req_total;
      xact(tbl[i].op, tbl[i].a, tbl[i].sd, tbl[i].rd, tbl[i].w, g);
      e = model(tbl[i].op, tbl[i].a, tbl[i].sd, tbl[i].rd, tbl[i].w);
      cmp($sformatf("vec%0d", i), g, e);
      chk($sformatf("vec%0d table_wdata", i), g.res, tbl[i].e_res);
      if (e.stall_n > 0) chk($sformatf("vec%0d table_sel", i), g.sel, tbl[i].e_sel);
      if (e.we) chk($sformatf("vec%0d table_bus_wdata", i), g.bwd, tbl[i].e_bwd);
      idle();
      if (e.stall_n == 0) begin
        @(negedge clk);
        chk($sformatf("vec%0d no_req", i), req_total - rt, 0);
        idle();
      end
    end
    xact(MEM_OP_LW, 32'h500, 32'h0, 32'h12345678, 10, g);
    cmp("timeout", g, model(MEM_OP_LW, 32'h500, 32'h0, 32'h12345678, 10));
    idle();
    @(negedge clk);
    chk("after timeout stallreq", stallreq_o, 1'b0);
    chk("after timeout bus_err", bus_err_o, 1'b0);
    chk("after timeout wreg", wreg_o, 1'b1);
    chk("after timeout wdata", wdata_o, pass_data(32'h500));
    idle();
    mem_op_i = MEM_OP_LW;
    mem_addr_i = 32'h600;
    wdata_i = pass_data(32'h600);
    @(negedge clk);
    chk("rst seq stallreq T", stallreq_o, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst seq req REQ1", bus.req, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst seq req during rst", bus.req, 1'b0);
    chk("rst seq wd_o during rst", wd_o, 5'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_op_i = MEM_OP_NONE;
    @(negedge clk);
    chk("rst seq req after", bus.req, 1'b0);
    chk("rst seq stallreq after", stallreq_o, 1'b0);
    idle();
    xact(MEM_OP_LW, 32'h700, 32'h0, 32'h11223344, 1, g);
    cmp("after rst LW", g, model(MEM_OP_LW, 32'h700, 32'h0, 32'h11223344, 1));
    idle();
    stall_i = 1'b1;
    xact(MEM_OP_LW, 32'h800, 32'h0, 32'hA5A55A5A, 0, g);
    chk("stall DONE wdata", g.res, 32'hA5A55A5A);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("stall hold%0d wdata", i), wdata_o, 32'hA5A55A5A);
      chk($sformatf("stall hold%0d stallreq", i), stallreq_o, 1'b0);
    end
    stall_i = 1'b0;
    idle();
    @(negedge clk);
    chk("stall release wdata", wdata_o, pass_data(32'h800));
    chk("stall release stallreq", stallreq_o, 1'b0);
    idle();
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 10));
      a = $urandom;
      sd = $urandom;
      rd = $urandom;
      w = int'($urandom_range(0, 5));
      xact(op, a, sd, rd, w, g);
      cmp($sformatf("rand%0d op%0d", i, op), g, model(op, a, sd, rd, w));
      idle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
